// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MUL/MULH/DIV/REM unit beside the EX-stage ALU.
// Define MULDIV_EARLY_EXIT_EN to finish MUL/MULH with a zero operand early.
module muldiv_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   res_q;
  logic               dbz_q;

  logic               take;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               zero_div;
  logic               zero_mul;
  logic               skip;

  logic [WIDTH:0]     acc_sum;
  logic [2*WIDTH-1:0] prod_nx;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic               neg_q;
  logic [WIDTH-1:0]   fin;

  // Request decode in IDLE
  assign take     = start & ~flush;
  assign sign_a   = ~is_unsigned & operand_a[WIDTH-1];
  assign sign_b   = ~is_unsigned & operand_b[WIDTH-1];
  assign a_mag    = sign_a ? -operand_a : operand_a;
  assign b_mag    = sign_b ? -operand_b : operand_b;
  assign zero_div = op[1] & (operand_b == '0);

`ifdef MULDIV_EARLY_EXIT_EN
  assign zero_mul = ~op[1] &
                    ((operand_a == '0) | (operand_b == '0));
`else
  assign zero_mul = 1'b0;
`endif

  assign skip = zero_div | zero_mul;

  // Shift-add multiply step
  assign acc_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                   (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_nx = {acc_sum, prod_q[WIDTH-1:1]};

  // Restoring divide step; no borrow means the divisor fits
  assign trial  = {rem_q, quo_q[WIDTH-1]};
  assign diff   = trial - {1'b0, b_q};
  assign fits   = ~diff[WIDTH];
  assign rem_nx = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], fits};

  assign neg_q  = sa_q ^ sb_q;
  assign prod_s = neg_q ? -prod_nx : prod_nx;

  always_comb begin
    fin = '0;
    unique case (op_q)
      OP_MUL:  fin = prod_s[WIDTH-1:0];
      OP_MULH: fin = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV:  fin = neg_q ? -quo_nx : quo_nx;
      OP_REM:  fin = sa_q ? -rem_nx : rem_nx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        stall = take;
        if (take) state_d = skip ? DONE : CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (flush)              state_d = IDLE;
        else if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      res_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (take) begin
        op_q   <= op;
        sa_q   <= sign_a;
        sb_q   <= sign_b;
        a_q    <= a_mag;
        b_q    <= b_mag;
        cnt_q  <= '0;
        prod_q <= {{WIDTH{1'b0}}, b_mag};
        rem_q  <= '0;
        quo_q  <= a_mag;
        dbz_q  <= zero_div;
        // Zero divisor: all-ones quotient, dividend as remainder
        if (zero_div)
          res_q <= op[0] ? operand_a : '1;
        else if (zero_mul)
          res_q <= '0;
      end
    end else if (state_q == CALC) begin
      if (!flush) begin
        cnt_q <= cnt_q + 1'b1;
        if (op_q[1]) begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
        end else begin
          prod_q <= prod_nx;
        end
        if (cnt_q == LAST) res_q <= fin;
      end
    end
  end

  assign result      = res_q;
  assign div_by_zero = done & dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random checks of muldiv_seq
// against an arithmetic reference model.
module tb_muldiv_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic       is_unsigned;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       flush;
  logic       stall;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  muldiv_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .is_unsigned (is_unsigned),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic void model(input logic [1:0] o,
                                input logic u,
                                input logic [7:0] a,
                                input logic [7:0] b,
                                output logic [7:0] r,
                                output logic z,
                                output int lat);
    int sa, sb, p, q, m;
    sa  = u ? int'(a) : int'($signed(a));
    sb  = u ? int'(b) : int'($signed(b));
    z   = 1'b0;
    lat = 9;
    r   = 8'h00;
    if (!o[1]) begin
      p = sa * sb;
      r = o[0] ? p[15:8] : p[7:0];
`ifdef MULDIV_EARLY_EXIT_EN
      if (a == 8'h00 || b == 8'h00) lat = 1;
`endif
    end else if (b == 8'h00) begin
      z   = 1'b1;
      lat = 1;
      r   = o[0] ? a : 8'hFF;
    end else begin
      q = sa / sb;
      m = sa % sb;
      r = o[0] ? m[7:0] : q[7:0];
    end
  endfunction

  task automatic run_op(input logic [1:0] o,
                        input logic u,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic hold,
                        input string tag);
    logic [7:0] er;
    logic       ez;
    int         elat;
    int         lat;
    int         stl;
    logic       seen;
    model(o, u, a, b, er, ez, elat);
    @(negedge clk);
    start       = 1'b1;
    op          = o;
    is_unsigned = u;
    operand_a   = a;
    operand_b   = b;
    #1;
    stl  = stall ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        seen = 1'b1;
        chk({tag, " result"}, 16'(result), 16'(er));
        chk({tag, " dbz"}, 16'(div_by_zero), 16'(ez));
      end else begin
        if (stall) stl++;
        start     = hold;
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
      end
    end
    chk({tag, " latency"}, 16'(lat), 16'(elat));
    chk({tag, " stall"}, 16'(stl), 16'(elat));
    @(posedge clk);
    #1;
    chk({tag, " single done"}, 16'(done), 16'd0);
    chk({tag, " idle"}, 16'(busy), 16'd0);
    chk({tag, " result hold"}, 16'(result), 16'(er));
    start = 1'b0;
  endtask

  initial begin
    logic       seen;
    logic [1:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] corners [4];
    corners[0] = 8'h00;
    corners[1] = 8'h80;
    corners[2] = 8'hFF;
    corners[3] = 8'h01;

    reset       = 1'b1;
    start       = 1'b0;
    flush       = 1'b0;
    op          = 2'b00;
    is_unsigned = 1'b1;
    operand_a   = 8'h00;
    operand_b   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset result", 16'(result), 16'd0);
    chk("reset dbz", 16'(div_by_zero), 16'd0);
    chk("reset stall", 16'(stall), 16'd0);
    reset = 1'b0;

    run_op(2'b00, 1'b1, 8'd13, 8'd11, 1'b0, "umul");
    run_op(2'b01, 1'b1, 8'd13, 8'd11, 1'b0, "umulh");
    run_op(2'b01, 1'b0, 8'hFD, 8'd5, 1'b1, "smulh");
    run_op(2'b00, 1'b0, 8'hFD, 8'd5, 1'b0, "smul");
    run_op(2'b10, 1'b0, 8'hF9, 8'd2, 1'b0, "sdiv");
    run_op(2'b11, 1'b0, 8'hF9, 8'd2, 1'b1, "srem");
    run_op(2'b10, 1'b0, 8'h80, 8'hFF, 1'b0, "ovf div");
    run_op(2'b11, 1'b0, 8'h80, 8'hFF, 1'b0, "ovf rem");
    run_op(2'b10, 1'b1, 8'd25, 8'd0, 1'b0, "dbz div");
    run_op(2'b11, 1'b1, 8'd25, 8'd0, 1'b1, "dbz rem");
    run_op(2'b11, 1'b0, 8'hE7, 8'd0, 1'b0, "dbz srem");
    run_op(2'b00, 1'b1, 8'd0, 8'd77, 1'b0, "mul zero");
    run_op(2'b01, 1'b0, 8'h80, 8'h80, 1'b0, "smulh min");

    // Flush in the 4th CALC cycle leaves result untouched
    run_op(2'b00, 1'b1, 8'd13, 8'd11, 1'b0, "pre flush");
    @(negedge clk);
    start     = 1'b1;
    op        = 2'b00;
    operand_a = 8'd200;
    operand_b = 8'd200;
    seen      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (done) seen = 1'b1;
    chk("flush busy", 16'(busy), 16'd0);
    chk("flush no done", 16'(seen), 16'd0);
    chk("flush result", 16'(result), 16'h008F);
    run_op(2'b10, 1'b1, 8'd100, 8'd7, 1'b0, "post flush");

    // Start with flush high is ignored
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("start+flush", 16'(busy), 16'd0);

    // Reset in the middle of CALC
    @(negedge clk);
    start     = 1'b1;
    op        = 2'b01;
    operand_a = 8'd250;
    operand_b = 8'd250;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst calc busy", 16'(busy), 16'd0);
    chk("rst calc done", 16'(done), 16'd0);
    chk("rst calc result", 16'(result), 16'd0);
    chk("rst calc dbz", 16'(div_by_zero), 16'd0);
    chk("rst calc stall", 16'(stall), 16'd0);
    reset = 1'b0;

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 4) == 0) ?
           corners[$urandom_range(0, 3)] : 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ?
           corners[$urandom_range(0, 3)] : 8'($urandom);
      run_op(ro, 1'($urandom), ra, rb, 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
